// File: rtl/l2_tag_ctrl.sv
// l2_tag_ctrl
//   Tag-array controller for a direct-mapped L2 with 32-byte lines. After reset
//   it sweeps every set to an invalid, clean, zero-tag entry. It then serves one
//   request at a time: a lookup reads the stored entry and reports hit, dirty
//   and the victim tag, and an update writes a new entry. The tag SRAM has one
//   write port (port 0) and one read port (port 1). Both ports are clocked by clk.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_op              0 = lookup, 1 = update
//   req_addr            byte address: tag [28:12], index [11:5], offset [4:0]
//   req_vbit/dirty      entry bits written by an update
//   resp_valid/ready    lookup result handshake
//   resp_hit/dirty      result flags, both qualified by the stored valid bit
//   resp_victim_*       raw stored valid bit and tag
//   init_done           invalidation sweep finished
//   tag_csb0/addr0/din0 SRAM write port, select active low
//   tag_csb1/addr1      SRAM read port, select active low
//   tag_dout1           SRAM read data, {valid, dirty, tag}
//
// States
//   state | meaning
//   INIT  | write an all-zero entry to each set, index 0 up to 127
//   IDLE  | req_ready=1, waiting for a request
//   RD    | read port selected at the index of the captured request
//   WAIT  | SRAM read data is valid; it is sampled at the end of this cycle
//   RESP  | result held stable until resp_ready
//   WR    | one write-port cycle for an update
module l2_tag_ctrl #(
    parameter int TAG_W = 17,
    parameter int IDX_W = 7,
    parameter int OFF_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_op,
    input  logic [TAG_W+IDX_W+OFF_W-1:0] req_addr,
    input  logic                         req_vbit,
    input  logic                         req_dirty,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_hit,
    output logic                         resp_dirty,
    output logic                         resp_victim_valid,
    output logic [TAG_W-1:0]             resp_victim_tag,
    output logic                         init_done,
    output logic                         tag_csb0,
    output logic [IDX_W-1:0]             tag_addr0,
    output logic [TAG_W+1:0]             tag_din0,
    output logic                         tag_csb1,
    output logic [IDX_W-1:0]             tag_addr1,
    input  logic [TAG_W+1:0]             tag_dout1
);

    localparam int ENT_W = TAG_W + 2;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WAIT,
        S_RESP,
        S_WR
    } state_t;

    state_t           state_q;
    logic [IDX_W:0]   init_cnt_q;   // MSB set once every index has been written
    logic [TAG_W-1:0] tag_q;        // tag of the lookup in flight

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic             rd_dirty;
    logic [TAG_W-1:0] rd_tag;
    logic             unused_offset;

    assign req_idx       = req_addr[OFF_W +: IDX_W];
    assign req_tag       = req_addr[OFF_W+IDX_W +: TAG_W];
    assign unused_offset = ^req_addr[OFF_W-1:0];

    assign rd_valid = tag_dout1[ENT_W-1];
    assign rd_dirty = tag_dout1[ENT_W-2];
    assign rd_tag   = tag_dout1[TAG_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_INIT;
            init_cnt_q        <= '0;
            tag_q             <= '0;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_dirty        <= 1'b0;
            resp_victim_valid <= 1'b0;
            resp_victim_tag   <= '0;
            init_done         <= 1'b0;
            tag_csb0          <= 1'b1;
            tag_addr0         <= '0;
            tag_din0          <= '0;
            tag_csb1          <= 1'b1;
            tag_addr1         <= '0;
        end else begin
            // Both SRAM ports idle with zeroed buses unless a state below selects one.
            tag_csb0  <= 1'b1;
            tag_addr0 <= '0;
            tag_din0  <= '0;
            tag_csb1  <= 1'b1;
            tag_addr1 <= '0;

            case (state_q)
                S_INIT: begin
                    if (init_cnt_q[IDX_W]) begin
                        state_q   <= S_IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        tag_csb0   <= 1'b0;
                        tag_addr0  <= init_cnt_q[IDX_W-1:0];
                        init_cnt_q <= init_cnt_q + {{IDX_W{1'b0}}, 1'b1};
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_op) begin
                            state_q   <= S_WR;
                            tag_csb0  <= 1'b0;
                            tag_addr0 <= req_idx;
                            tag_din0  <= {req_vbit, req_dirty & req_vbit, req_tag};
                        end else begin
                            state_q   <= S_RD;
                            tag_csb1  <= 1'b0;
                            tag_addr1 <= req_idx;
                            tag_q     <= req_tag;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    state_q           <= S_RESP;
                    resp_valid        <= 1'b1;
                    resp_hit          <= rd_valid && (rd_tag == tag_q);
                    resp_dirty        <= rd_valid && rd_dirty;
                    resp_victim_valid <= rd_valid;
                    resp_victim_tag   <= rd_tag;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q           <= S_IDLE;
                        req_ready         <= 1'b1;
                        resp_valid        <= 1'b0;
                        resp_hit          <= 1'b0;
                        resp_dirty        <= 1'b0;
                        resp_victim_valid <= 1'b0;
                        resp_victim_tag   <= '0;
                    end
                end
                S_WR: begin
                    state_q   <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Bench for l2_tag_ctrl. The tag SRAM is modelled behind the DUT ports. The
// expected contents of each set are kept as a plain array written from the
// update rule. Expected outputs for every cycle are set by the transaction tasks.
module tb_l2_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_op, req_vbit, req_dirty, resp_ready;
    logic [28:0] req_addr;
    logic        req_ready, resp_valid, resp_hit, resp_dirty, resp_victim_valid, init_done;
    logic [16:0] resp_victim_tag;
    logic        tag_csb0, tag_csb1;
    logic [6:0]  tag_addr0, tag_addr1;
    logic [18:0] tag_din0;
    logic [18:0] tag_dout1 = 19'h0;

    // The SRAM starts full of valid-looking garbage, so a skipped init write shows up.
    logic [18:0] sram [128] = '{default: 19'h7ffff};

    always #5 clk = ~clk;

    // The read data appears after the edge that samples the select. It is scrambled
    // in other cycles, so the DUT cannot rely on a stale value.
    always @(posedge clk) begin
        if (!tag_csb0) sram[tag_addr0] <= tag_din0;
        if (!tag_csb1) tag_dout1 <= sram[tag_addr1];
        else           tag_dout1 <= 19'($urandom);
    end

    l2_tag_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_vbit          (req_vbit),
        .req_dirty         (req_dirty),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_hit          (resp_hit),
        .resp_dirty        (resp_dirty),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_tag   (resp_victim_tag),
        .init_done         (init_done),
        .tag_csb0          (tag_csb0),
        .tag_addr0         (tag_addr0),
        .tag_din0          (tag_din0),
        .tag_csb1          (tag_csb1),
        .tag_addr1         (tag_addr1),
        .tag_dout1         (tag_dout1)
    );

    logic        e_csb0, e_csb1, e_ready, e_rv, e_hit, e_dirty, e_vv, e_done, e_chk_resp;
    logic [6:0]  e_addr0, e_addr1;
    logic [18:0] e_din0;
    logic [16:0] e_vtag;
    logic [18:0] shadow [128];

    logic [6:0]  cap_addr0, cap_addr1;
    logic [18:0] cap_din0;
    logic        cap_hit, cap_dirty, cap_vv;
    logic [16:0] cap_vtag;
    int          cap_lat;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic set_base_exp(input logic ready, input logic done);
        e_csb0 = 1'b1; e_addr0 = '0; e_din0 = '0;
        e_csb1 = 1'b1; e_addr1 = '0;
        e_ready = ready; e_done = done;
        e_rv = 1'b0; e_chk_resp = 1'b0;
        e_hit = 1'b0; e_dirty = 1'b0; e_vv = 1'b0; e_vtag = '0;
    endtask

    task automatic set_reset_exp();
        set_base_exp(1'b0, 1'b0);
        e_chk_resp = 1'b1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("tag_csb0",  32'(tag_csb0),  32'(e_csb0));
            chk("tag_addr0", 32'(tag_addr0), 32'(e_addr0));
            chk("tag_din0",  32'(tag_din0),  32'(e_din0));
            chk("tag_csb1",  32'(tag_csb1),  32'(e_csb1));
            chk("tag_addr1", 32'(tag_addr1), 32'(e_addr1));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("init_done", 32'(init_done), 32'(e_done));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_rv || e_chk_resp) begin
                chk("resp_hit",          32'(resp_hit),          32'(e_hit));
                chk("resp_dirty",        32'(resp_dirty),        32'(e_dirty));
                chk("resp_victim_valid", 32'(resp_victim_valid), 32'(e_vv));
                chk("resp_victim_tag",   32'(resp_victim_tag),   32'(e_vtag));
            end
        end
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom);
        req_op    = 1'($urandom);
        req_addr  = 29'($urandom);
        req_vbit  = 1'($urandom);
        req_dirty = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            junk_req();
            req_valid  = 1'b0;
            resp_ready = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic init_sweep(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            set_base_exp(1'b0, 1'b0);
            e_csb0  = 1'b0;
            e_addr0 = 7'(k);
            junk_req();
            resp_ready = 1'($urandom);
        end
        if (n == 128) begin
            @(posedge clk); #1;
            set_base_exp(1'b1, 1'b1);
            req_valid = 1'b0;
            chk("init_done_cycle129", 32'(init_done), 32'd1);
            chk("req_ready_cycle129", 32'(req_ready), 32'd1);
        end
    endtask

    task automatic assert_rst_midcycle();
        @(negedge clk); #1;
        rst = 1'b1;
        set_reset_exp();
        for (int i = 0; i < 128; i++) shadow[i] = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_csb0",       32'(tag_csb0),   32'd1);
        chk("rst_csb1",       32'(tag_csb1),   32'd1);
        chk("rst_addr0",      32'(tag_addr0),  32'd0);
        chk("rst_init_done",  32'(init_done),  32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_update(input logic [28:0] a, input logic v, input logic d);
        logic [6:0]  idx;
        logic [16:0] tg;
        idx = a[11:5];
        tg  = a[28:12];
        req_valid = 1'b1; req_op = 1'b1; req_addr = a; req_vbit = v; req_dirty = d;
        resp_ready = 1'($urandom);
        @(posedge clk); #1;
        shadow[idx] = {v, d & v, tg};
        set_base_exp(1'b0, 1'b1);
        e_csb0 = 1'b0; e_addr0 = idx; e_din0 = shadow[idx];
        cap_addr0 = tag_addr0;
        cap_din0  = tag_din0;
        junk_req();
        resp_ready = 1'($urandom);
        @(posedge clk); #1;
        set_base_exp(1'b1, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [28:0] a, input int hold, input bit abort);
        logic [6:0]  idx;
        logic [16:0] tg;
        logic [18:0] ent;
        idx = a[11:5];
        tg  = a[28:12];
        req_valid = 1'b1; req_op = 1'b0; req_addr = a;
        req_vbit = 1'($urandom); req_dirty = 1'($urandom);
        resp_ready = 1'($urandom);
        @(posedge clk); #1;
        ent = shadow[idx];
        set_base_exp(1'b0, 1'b1);
        e_csb1 = 1'b0; e_addr1 = idx;
        cap_addr1 = tag_addr1;
        cap_lat = resp_valid ? 1 : 0;
        junk_req();
        resp_ready = 1'($urandom);
        @(posedge clk); #1;
        set_base_exp(1'b0, 1'b1);
        if (resp_valid && cap_lat == 0) cap_lat = 2;
        junk_req();
        resp_ready = 1'($urandom);
        @(posedge clk); #1;
        if (resp_valid && cap_lat == 0) cap_lat = 3;
        set_base_exp(1'b0, 1'b1);
        e_rv    = 1'b1;
        e_vv    = ent[18];
        e_hit   = ent[18] && (ent[16:0] == tg);
        e_dirty = ent[18] && ent[17];
        e_vtag  = ent[16:0];
        cap_hit = resp_hit; cap_dirty = resp_dirty; cap_vv = resp_victim_valid; cap_vtag = resp_victim_tag;
        junk_req();
        resp_ready = (hold == 0);
        if (abort) return;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk); #1;
            junk_req();
            resp_ready = (i == hold);
        end
        @(posedge clk); #1;
        set_base_exp(1'b1, 1'b1);
        req_valid  = 1'b0;
        resp_ready = 1'($urandom);
    endtask

    logic [16:0] tags [4];
    logic [6:0]  idxs [4];

    initial begin
        logic [28:0] a;
        rst = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_vbit = 1'b0; req_dirty = 1'b0;
        resp_ready = 1'b0;
        for (int i = 0; i < 128; i++) shadow[i] = '0;
        set_reset_exp();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        fork compare_loop(); join_none
        chk("reset_csb0",      32'(tag_csb0),   32'd1);
        chk("reset_csb1",      32'(tag_csb1),   32'd1);
        chk("reset_req_ready", 32'(req_ready),  32'd0);
        chk("reset_init_done", 32'(init_done),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_sweep(128);

        // Directed sequence on index 26.
        do_lookup(29'h0001_2340, 0, 1'b0);
        chk("lk1_addr1",   32'(cap_addr1), 32'd26);
        chk("lk1_latency", 32'(cap_lat),   32'd3);
        chk("lk1_hit",     32'(cap_hit),   32'd0);
        chk("lk1_vv",      32'(cap_vv),    32'd0);
        do_update(29'h0001_2340, 1'b1, 1'b1);
        chk("up1_addr0", 32'(cap_addr0), 32'd26);
        chk("up1_din0",  32'(cap_din0),  32'h60012);
        do_lookup(29'h0001_2340, 0, 1'b0);
        chk("lk2_hit",   32'(cap_hit),   32'd1);
        chk("lk2_dirty", 32'(cap_dirty), 32'd1);
        do_lookup(29'h0002_2340, 5, 1'b0);
        chk("lk3_hit",   32'(cap_hit),   32'd0);
        chk("lk3_vv",    32'(cap_vv),    32'd1);
        chk("lk3_vtag",  32'(cap_vtag),  32'h12);
        chk("lk3_dirty", 32'(cap_dirty), 32'd1);
        do_update(29'h0001_2340, 1'b0, 1'b1);
        chk("up2_din0", 32'(cap_din0), 32'h00012);
        do_lookup(29'h0001_2340, 1, 1'b0);
        chk("lk4_vv",    32'(cap_vv),    32'd0);
        chk("lk4_dirty", 32'(cap_dirty), 32'd0);

        // Random traffic over a few sets, including both index extremes.
        tags[0] = 17'h12; tags[1] = 17'($urandom); tags[2] = 17'($urandom); tags[3] = 17'h1ffff;
        idxs[0] = 7'd0;   idxs[1] = 7'd127;        idxs[2] = 7'd26;         idxs[3] = 7'($urandom);
        for (int n = 0; n < 400; n++) begin
            a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 5'($urandom)};
            if ($urandom_range(0, 1) == 1) do_update(a, 1'($urandom), 1'($urandom));
            else                           do_lookup(a, int'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        // Reset while a result is waiting.
        do_update(29'h0001_2340, 1'b1, 1'b0);
        do_lookup(29'h0001_2340, 3, 1'b1);
        assert_rst_midcycle();
        init_sweep(128);

        // Reset in the middle of the sweep, then a full sweep.
        assert_rst_midcycle();
        init_sweep(61);
        chk("init_abort_index", 32'(tag_addr0), 32'd60);
        assert_rst_midcycle();
        init_sweep(128);
        do_lookup(29'h0001_2340, 0, 1'b0);
        chk("post_reinit_vv",  32'(cap_vv),  32'd0);
        chk("post_reinit_hit", 32'(cap_hit), 32'd0);
        idle_cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_tag_ctrl.md
L2_TAG_CTRL -- requirements
Module: l2_tag_ctrl

Interface
REQ-001 SHALL have parameters: TAG_W, 17, tag bits = req_addr[28:12]; IDX_W, 7, set index = req_addr[11:5]; OFF_W, 5, line offset = req_addr[4:0] (32 B lines).
REQ-002 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset is permitted.
REQ-003 SHALL have ports (name direction width meaning), clock and reset first:
- clk in 1 sole clock; also drives both tag SRAM clock pins
- rst in 1 asynchronous active-high reset
- req_valid in 1 request present
- req_ready out 1 request accepted when req_valid && req_ready at posedge
- req_op in 1 0 = lookup, 1 = update
- req_addr in 29 physical byte address
- req_vbit in 1 update: valid bit to write (0 = invalidate)
- req_dirty in 1 update: dirty bit to write
- resp_valid out 1 lookup result present
- resp_ready in 1 consumer takes result
- resp_hit out 1 stored valid && stored tag == request tag
- resp_dirty out 1 stored valid && stored dirty
- resp_victim_valid out 1 stored valid bit
- resp_victim_tag out 17 stored tag
- init_done out 1 invalidation sweep complete
- tag_csb0 out 1 tag SRAM write-port select, active low
- tag_addr0 out 7 tag SRAM write index
- tag_din0 out 19 tag SRAM write entry {valid, dirty, tag[16:0]}
- tag_csb1 out 1 tag SRAM read-port select, active low
- tag_addr1 out 7 tag SRAM read index
- tag_dout1 in 19 tag SRAM read entry, same format as tag_din0

Function
REQ-004 SHALL implement states INIT, IDLE, RD, WAIT, RESP, WR; all SRAM-side outputs registered.
REQ-005 INIT SHALL write 19'h0 to index 0..127 in ascending order, one write per cycle (tag_csb0=0), then go to IDLE with init_done=1.
REQ-006 req_ready SHALL be 1 only in IDLE; every other state SHALL hold req_ready=0.
REQ-007 An accepted lookup SHALL capture req_addr and go IDLE->RD->WAIT->RESP; in RD, tag_csb1=0 and tag_addr1=index.
REQ-008 tag_dout1 SHALL be sampled only at the posedge ending WAIT; resp_valid SHALL rise 3 cycles after the accept edge.
REQ-009 In RESP, all resp_* outputs SHALL stay stable until resp_ready=1; the block SHALL then return to IDLE with resp_valid=0 on the next cycle.
REQ-010 An accepted update SHALL go to WR for exactly one cycle and then return to IDLE; it produces no response.
REQ-011 In WR: tag_csb0=0, tag_addr0=index, tag_din0={req_vbit, req_dirty&req_vbit, tag}.
REQ-012 tag_csb0 and tag_csb1 SHALL never both be 0 in the same cycle.
REQ-013 Whenever a select is 1, its address outputs and tag_din0 SHALL be 0.
REQ-014 With one operation in flight, a lookup issued directly after an update to the same index SHALL return the updated entry.
REQ-015 req_* inputs SHALL be ignored outside IDLE.
REQ-016 resp_ready SHALL be ignored outside RESP.

Reset
REQ-017 While rst=1, the outputs SHALL be: tag_csb0=tag_csb1=1; addresses, tag_din0, req_ready, resp_*, init_done all 0; index counter 0.
REQ-018 rst asserted in any state SHALL abandon the operation in progress, drop resp_valid, and restart INIT at index 0 on the first clock after release.

Verification
REQ-019 Reset release -> 128 consecutive writes (addr 0..127, din 0); init_done=1 and req_ready=1 on the 129th cycle.
REQ-020 Lookup 29'h0001_2340 after init -> tag_addr1=7'd26; 3 cycles later resp_valid=1, resp_hit=0, resp_victim_valid=0.
REQ-021 Update 29'h0001_2340 with vbit=1, dirty=1 -> tag_addr0=26, tag_din0=19'h60012; a following lookup of the same address -> resp_hit=1, resp_dirty=1.
REQ-022 Lookup 29'h0002_2340 (same index, tag 0x22) -> resp_hit=0, resp_victim_valid=1, resp_victim_tag=17'h12, resp_dirty=1.
REQ-023 resp_ready held 0 for 5 cycles during RESP -> resp_* stable, req_ready=0 and both selects high throughout.
REQ-024 rst pulsed during INIT at index 60 -> outputs take reset values immediately; the sweep restarts at index 0 and completes all 128 writes.
